// File: rtl/div_frec_multi.sv
// Multi-channel programmable frequency divider.
// Each channel divides CLK by a run-time divisor and produces a 50% duty
// divided clock plus a one-cycle tick at every divided-clock toggle.
// A new divisor is parked in a shadow register and only takes effect at a
// terminal count, or at once while the channel is stopped. Sync re-phases
// all channels together.
module div_frec_multi #(
    parameter int WIDTH       = 9,
    parameter int CHANNELS    = 2,
    parameter int DEFAULT_DIV = 499,
    parameter int CHW         = 1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] En,
    input  logic                Load,
    input  logic [CHW-1:0]      Load_Ch,
    input  logic [WIDTH-1:0]    Load_Div,
    input  logic                Sync,
    output logic [CHANNELS-1:0] DivCLK,
    output logic [CHANNELS-1:0] Tick,
    output logic                Load_Ack
);

    localparam logic [WIDTH-1:0] DefDiv  = WIDTH'(DEFAULT_DIV);
    localparam logic [CHW:0]     ChCount = (CHW + 1)'(CHANNELS);

    logic [CHANNELS-1:0][WIDTH-1:0] q_q,   q_d;
    logic [CHANNELS-1:0][WIDTH-1:0] div_q, div_d;
    logic [CHANNELS-1:0][WIDTH-1:0] shd_q, shd_d;
    logic [CHANNELS-1:0]            pend_q,   pend_d;
    logic [CHANNELS-1:0]            divClk_q, divClk_d;
    logic [CHANNELS-1:0]            tick_q,   tick_d;
    logic                           ack_q,    ack_d;

    logic                           loadValid;
    logic [CHANNELS-1:0]            newLoad;
    logic [CHANNELS-1:0]            terminal;

    // A load addressed past the last channel is silently dropped.
    assign loadValid = Load && ({1'b0, Load_Ch} < ChCount);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign newLoad[g]  = loadValid && (Load_Ch == CHW'(g));
        // >= rather than == so a divisor that shrank below q still terminates.
        assign terminal[g] = (q_q[g] >= div_q[g]);
    end

    // Next-state: Sync dominates; otherwise count, toggle and hand over the shadow divisor.
    always_comb begin
        q_d      = q_q;
        div_d    = div_q;
        shd_d    = shd_q;
        pend_d   = pend_q;
        divClk_d = divClk_q;
        tick_d   = '0;
        ack_d    = loadValid;
        for (int i = 0; i < CHANNELS; i++) begin
            if (newLoad[i]) begin
                shd_d[i] = Load_Div;
            end
            if (Sync) begin
                q_d[i]      = '0;
                divClk_d[i] = 1'b0;
                div_d[i]    = newLoad[i] ? Load_Div : shd_q[i];
                pend_d[i]   = 1'b0;
            end else begin
                if (En[i]) begin
                    if (terminal[i]) begin
                        q_d[i]      = '0;
                        divClk_d[i] = ~divClk_q[i];
                        tick_d[i]   = 1'b1;
                    end else begin
                        q_d[i] = q_q[i] + WIDTH'(1);
                    end
                end
                if (pend_q[i] && (!En[i] || terminal[i])) begin
                    div_d[i]  = shd_q[i];
                    pend_d[i] = 1'b0;
                end
                if (newLoad[i]) begin
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    // State register with asynchronous active-low reset back to the default divisor.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            q_q      <= '0;
            div_q    <= {CHANNELS{DefDiv}};
            shd_q    <= {CHANNELS{DefDiv}};
            pend_q   <= '0;
            divClk_q <= '0;
            tick_q   <= '0;
            ack_q    <= 1'b0;
        end else begin
            q_q      <= q_d;
            div_q    <= div_d;
            shd_q    <= shd_d;
            pend_q   <= pend_d;
            divClk_q <= divClk_d;
            tick_q   <= tick_d;
            ack_q    <= ack_d;
        end
    end

    assign DivCLK   = divClk_q;
    assign Tick     = tick_q;
    assign Load_Ack = ack_q;

endmodule

// File: tb/tb_div_frec_multi.sv
// Testbench for div_frec_multi: directed phases plus a randomized phase,
// with expected outputs produced by a half-period reference model and
// checked by an independent scoreboard monitor.
module tb_div_frec_multi;

    localparam int WIDTH       = 9;
    localparam int CHANNELS    = 2;
    localparam int DEFAULT_DIV = 499;
    localparam int CHW         = 2;

    logic                CLK = 1'b0;
    logic                Reset = 1'b0;
    logic [CHANNELS-1:0] En = '0;
    logic                Load = 1'b0;
    logic [CHW-1:0]      Load_Ch = '0;
    logic [WIDTH-1:0]    Load_Div = '0;
    logic                Sync = 1'b0;
    logic [CHANNELS-1:0] DivCLK;
    logic [CHANNELS-1:0] Tick;
    logic                Load_Ack;

    div_frec_multi #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEFAULT_DIV(DEFAULT_DIV), .CHW(CHW)
    ) dut (
        .CLK(CLK), .Reset(Reset), .En(En), .Load(Load), .Load_Ch(Load_Ch),
        .Load_Div(Load_Div), .Sync(Sync), .DivCLK(DivCLK), .Tick(Tick),
        .Load_Ack(Load_Ack)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] divClk;
        logic [1:0] tick;
        logic       ack;
    } expT;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;
    int  cycle  = 0;

    // Reference model: each channel is a half-period of (divisor+1) enabled cycles.
    int activeDiv[CHANNELS];
    int shadowDiv[CHANNELS];
    int spent[CHANNELS];
    bit pending[CHANNELS];
    bit level[CHANNELS];

    function automatic void modelReset();
        for (int c = 0; c < CHANNELS; c++) begin
            activeDiv[c] = DEFAULT_DIV;
            shadowDiv[c] = DEFAULT_DIV;
            spent[c]     = 0;
            pending[c]   = 1'b0;
            level[c]     = 1'b0;
        end
    endfunction

    function automatic expT modelStep(input logic [1:0] en, input logic ld,
                                      input int ch, input int ldiv, input logic sync);
        expT e;
        bit  accepted;
        bit  hit;
        bit  toggled;
        accepted = ld && (ch < CHANNELS);
        e.ack    = accepted;
        e.tick   = '0;
        e.divClk = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hit     = accepted && (ch == c);
            toggled = 1'b0;
            if (sync) begin
                if (hit) shadowDiv[c] = ldiv;
                activeDiv[c] = shadowDiv[c];
                pending[c]   = 1'b0;
                spent[c]     = 0;
                level[c]     = 1'b0;
            end else begin
                if (en[c]) begin
                    // This enabled cycle ends the half-period once (divisor+1) cycles are used up.
                    if (spent[c] + 1 >= activeDiv[c] + 1) begin
                        toggled  = 1'b1;
                        spent[c] = 0;
                        level[c] = !level[c];
                    end else begin
                        spent[c]++;
                    end
                end
                if (pending[c] && (!en[c] || toggled)) begin
                    activeDiv[c] = shadowDiv[c];
                    pending[c]   = 1'b0;
                end
                if (hit) begin
                    shadowDiv[c] = ldiv;
                    pending[c]   = 1'b1;
                end
            end
            e.tick[c]   = toggled;
            e.divClk[c] = level[c];
        end
        return e;
    endfunction

    // Drive one cycle of inputs, record the expected result, and advance to the next drive point.
    task automatic applyStimulus(input logic [1:0] en, input logic ld, input int ch,
                                 input int ldiv, input logic sync);
        En       = en;
        Load     = ld;
        Load_Ch  = CHW'(ch);
        Load_Div = WIDTH'(ldiv);
        Sync     = sync;
        expQ.push_back(modelStep(en, ld, ch, ldiv, sync));
        @(posedge CLK);
        #6;
    endtask

    task automatic idle(input int n, input logic [1:0] en);
        for (int k = 0; k < n; k++) applyStimulus(en, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got DivCLK/Tick/Ack=%b expected %b",
                     name, cycle, actual, expected);
        end
    endtask

    // Scoreboard monitor: pops one expectation per clock and compares it to the DUT.
    initial begin : monitor
        expT e;
        forever begin
            @(posedge CLK);
            cycle++;
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("outputs", {DivCLK, Tick, Load_Ack}, e);
            end
        end
    end

    // Stimulus: directed phases following the test plan, then random traffic, then async reset.
    initial begin : stim
        modelReset();
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_state", {DivCLK, Tick, Load_Ack}, 5'b0);
        @(posedge CLK);
        #6;
        Reset = 1'b1;

        idle(2100, 2'b11);

        idle(150, 2'b11);
        applyStimulus(2'b11, 1'b1, 0, 3, 1'b0);
        idle(1200, 2'b11);

        applyStimulus(2'b11, 1'b1, 2, 7, 1'b0);
        applyStimulus(2'b11, 1'b1, 3, 7, 1'b0);
        idle(600, 2'b11);

        idle(100, 2'b01);
        idle(700, 2'b11);
        applyStimulus(2'b01, 1'b1, 1, 0, 1'b0);
        idle(5, 2'b01);
        idle(50, 2'b11);

        applyStimulus(2'b11, 1'b1, 0, 499, 1'b0);
        idle(20, 2'b11);
        applyStimulus(2'b11, 1'b1, 1, 9, 1'b1);
        idle(1100, 2'b11);

        for (int k = 0; k < 3000; k++) begin
            logic [1:0] en;
            logic       ld;
            logic       sy;
            en[0] = ($urandom_range(0, 9) != 0);
            en[1] = ($urandom_range(0, 9) != 0);
            ld    = ($urandom_range(0, 19) == 0);
            sy    = ($urandom_range(0, 99) == 0);
            applyStimulus(en, ld, $urandom_range(0, 3), $urandom_range(0, 24), sy);
        end

        applyStimulus(2'b11, 1'b1, 1, 5, 1'b0);
        applyStimulus(2'b11, 1'b1, 0, 5, 1'b0);
        idle(3, 2'b11);
        #1;
        Reset = 1'b0;
        #1;
        checkOutput("async_reset", {DivCLK, Tick, Load_Ack}, 5'b0);
        modelReset();
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_hold", {DivCLK, Tick, Load_Ack}, 5'b0);
        #5;
        Reset = 1'b1;
        idle(2100, 2'b11);

        @(posedge CLK);
        #4;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_frec_multi.md
Name: div_frec_multi

Overview:
- Parametrised, multi-channel successor to the single fixed-ratio frequency divider.
- Each channel divides the system clock by a run-time programmable ratio and produces two outputs: a 50% duty divided clock and a one-cycle tick strobe.
- Divisor updates are glitch-free, and a global sync re-phases all channels.
- Sits between the board oscillator and the display/scan/debounce logic that currently uses fixed dividers.

Parameters:
- WIDTH, 9: counter and divisor width in bits.
- CHANNELS, 2: number of independent divider channels.
- DEFAULT_DIV, 499: divisor loaded into every channel at reset (matches the existing fixed ratio).
- CHW, 1: width of the channel select; must satisfy 2**CHW >= CHANNELS.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- En  input  CHANNELS  per-channel count enable.
- Load  input  1  one-cycle request to write Load_Div into channel Load_Ch.
- Load_Ch  input  CHW  target channel for Load.
- Load_Div  input  WIDTH  new divisor value.
- Sync  input  1  one-cycle global restart of all channels.
- DivCLK  output  CHANNELS  divided clocks, registered.
- Tick  output  CHANNELS  one-CLK-cycle strobe at each DivCLK toggle, registered.
- Load_Ack  output  1  one-cycle acknowledge of an accepted Load, registered.

Behaviour:
- Per-channel state: counter q[WIDTH], active divisor div, shadow divisor shd, pending flag pend.
- Reset asserted (async):
  - q=0, div=shd=DEFAULT_DIV, pend=0.
  - DivCLK=0, Tick=0, Load_Ack=0.
- Counting, En[i]=1, no Sync:
  - Terminal condition is q >= div (>= protects against a divisor shrink).
  - At terminal: q<=0, DivCLK[i] toggles, Tick[i]<=1; if pend then div<=shd and pend<=0.
  - Otherwise: q<=q+1, Tick[i]<=0.
  - DivCLK period = 2*(div+1) CLK cycles; Tick period = div+1 cycles.
- div=0: DivCLK toggles every cycle (CLK/2) and Tick stays high continuously.
- En[i]=0:
  - q and DivCLK[i] hold; Tick[i]=0.
  - A pending shadow is applied immediately (div<=shd, pend<=0), since there is no glitch risk while stopped.
- Load (sampled each cycle):
  - If Load_Ch < CHANNELS: shd[Load_Ch]<=Load_Div, pend<=1, Load_Ack<=1 on the next cycle.
  - If Load_Ch >= CHANNELS: ignored, no ack.
  - A second Load to the same channel before its terminal count overwrites shd; only the last value is applied.
  - A Load landing on the terminal cycle is applied at the following terminal, never mid-period.
- Sync (highest priority after reset):
  - All channels: q<=0, DivCLK<=0, Tick<=0.
  - Every pending shadow is applied (div<=shd, pend<=0).
  - A Load in the same cycle is captured and applied by this Sync; Load_Ack still pulses.
  - Counting resumes on the next cycle for enabled channels.
  - Sync while En=0 still clears that channel.
- Reset mid-operation: immediate return to reset values; pending loads are discarded.
- Arithmetic: q+1 is evaluated at WIDTH bits. It never wraps, because terminal detection (q >= div) clears q first.
- Channels are fully independent except for the shared Sync and the shared Load port.

Test Plan:
- Reset release, En=2'b11, default divisor: DivCLK[0] and DivCLK[1] first rise after 500 cycles, period 1000 cycles; Tick pulses every 500 cycles, one cycle wide.
- Load ch0 Load_Div=3 mid-period: Load_Ack high one cycle later; current 500-cycle half-period completes unchanged, then DivCLK[0] period becomes 8 cycles; ch1 is unaffected.
- Load_Ch=2 with CHANNELS=2: no Load_Ack; no divisor changes on either channel.
- En[1]=0 for 100 cycles mid-count, then re-enabled: q and DivCLK[1] hold, Tick[1]=0 throughout; the interrupted half-period completes with 100 extra cycles. Load_Div=0 while disabled, then enabled: DivCLK[1] toggles every cycle.
- Sync pulsed with Load ch1 Load_Div=9 in the same cycle: both DivCLK=0 and q=0 next cycle; ch1 period 20 cycles and ch0 period 1000 cycles from that point; Load_Ack pulses.
- Reset asserted asynchronously between clock edges mid-period with a pending load: outputs clear immediately; after release the default 1000-cycle period applies and the pending divisor is discarded.
